gerador_de_padrao: RTL and testbench

//  Serial pattern transmitter: on a start pulse it shifts a fixed PAT_W-bit pattern out on x_out, MSB first, one bit per clock.
//  It repeats the pattern 'count' times, then signals done.

---
 rtl/gerador_de_padrao_pkg.sv | 20 ++
 rtl/gerador_de_padrao_if.sv | 36 +++
 rtl/gerador_de_padrao.sv | 199 +++++++++++++++++++
 tb/tb_gerador_de_padrao.sv | 137 +++++++++++++
 4 files changed

// File: rtl/gerador_de_padrao_pkg.sv
// -----------------------------------------------------------------------------
// gerador_pkg
//   Shared types and constants for the serial pattern transmitter.
//   - state_t  : transmitter FSM states. GAP is only reachable when the
//                design is built with GAPR_GAP_EN defined.
//   - PAT_1101 : default pattern. It gives exactly one serial-detector hit
//                per repetition.
// -----------------------------------------------------------------------------
package gerador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [3:0] PAT_1101 = 4'b1101;

endpackage

// File: rtl/gerador_de_padrao_if.sv
// -----------------------------------------------------------------------------
// gerador_de_padrao_if
//   Control and serial-output bundle of the pattern transmitter.
//   Signals:
//     start  1      request pulse; acted on only while the transmitter is idle
//     count  CNT_W  number of pattern repetitions, latched together with start
//     x_out  1      serial data bit
//     valid  1      x_out carries a pattern bit this cycle
//     busy   1      transmission in progress (start is ignored)
//     done   1      one-cycle completion pulse
//   Modports:
//     master : requester side (drives start/count)
//     slave  : transmitter side (drives the serial outputs)
// -----------------------------------------------------------------------------
interface gerador_de_padrao_if #(
  parameter int CNT_W = 4
);

  logic             start;
  logic [CNT_W-1:0] count;
  logic             x_out;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, count,
    input  x_out, valid, busy, done
  );

  modport slave (
    input  start, count,
    output x_out, valid, busy, done
  );

endinterface

// File: rtl/gerador_de_padrao.sv
// -----------------------------------------------------------------------------
// gerador_de_padrao
//   Serial pattern transmitter. A start pulse with a non-zero count makes the
//   block shift PATTERN out on x_out, MSB first, one bit per clock. It does
//   this 'count' times and then pulses done for one cycle. A start with
//   count == 0 goes straight to the done pulse.
//
//   Ports:
//     clock  in   rising-edge clock
//     reset  in   synchronous, active-high
//     bus    slave modport of gerador_de_padrao_if
//            (start, count in; x_out, valid, busy, done out)
//
//   Optional build macro:
//     GAPR_GAP_EN  When defined, the block inserts GAP_LEN idle '0' bits
//                  between repetitions. No gap follows the last repetition.
//                  When undefined, repetitions are back-to-back and GAP_LEN
//                  is unused.
//
//   Timing:
//     All outputs are registered.
//     The first bit appears in the cycle after start is accepted.
//     The number of cycles from the start edge to done is
//       count*PAT_W (+ (count-1)*GAP_LEN when gaps are enabled) + 1.
// -----------------------------------------------------------------------------
module gerador_de_padrao
  import gerador_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PAT_1101),
  parameter int               CNT_W   = 4,
  parameter int               GAP_LEN = 2
) (
  input  logic               clock,
  input  logic               reset,
  gerador_de_padrao_if.slave bus
);

  localparam int               IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);

  // Datapath and FSM state.
  state_t           state_q, state_d;
  logic [PAT_W-1:0] sr_q, sr_d;      // sr_q[PAT_W-1] is the bit currently on x_out
  logic [IDX_W-1:0] bit_q, bit_d;    // index of the bit currently on x_out
  logic [CNT_W-1:0] rep_q, rep_d;    // repetitions still owed, current one included

  // Registered outputs.
  logic x_q, x_d;
  logic valid_q, valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

`ifdef GAPR_GAP_EN
  localparam int               GAP_W    = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  logic [GAP_W-1:0] gap_q, gap_d;    // index of the idle cycle in the current gap
`endif

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic.
  // The registers hold what is on the bus in the current cycle. This block
  // therefore computes what the bus shows in the next cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    x_d     = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
`ifdef GAPR_GAP_EN
    gap_d   = gap_q;
`endif

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          busy_d = 1'b1;
          if (bus.count != '0) begin
            state_d = SEND;
            rep_d   = bus.count;
            sr_d    = PATTERN;
            bit_d   = '0;
            x_d     = PATTERN[PAT_W-1];
            valid_d = 1'b1;
          end else begin
            // Nothing to send: acknowledge immediately.
            state_d = FIN;
            done_d  = 1'b1;
          end
        end
      end

      SEND: begin
        if (bit_q == LAST_IDX) begin
          rep_d = rep_q - REP_ONE;
          if (rep_q == REP_ONE) begin
            state_d = FIN;
            bit_d   = '0;
            done_d  = 1'b1;
          end else begin
`ifdef GAPR_GAP_EN
            if (GAP_LEN > 0) begin
              state_d = GAP;
              gap_d   = '0;
              sr_d    = PATTERN;
              bit_d   = '0;
            end else begin
              sr_d    = PATTERN;
              bit_d   = '0;
              x_d     = PATTERN[PAT_W-1];
              valid_d = 1'b1;
            end
`else
            // Back-to-back: the first bit of the next repetition follows at once.
            sr_d    = PATTERN;
            bit_d   = '0;
            x_d     = PATTERN[PAT_W-1];
            valid_d = 1'b1;
`endif
          end
        end else begin
          bit_d   = bit_q + IDX_W'(1);
          sr_d    = sr_q << 1;
          x_d     = sr_q[PAT_W-2];
          valid_d = 1'b1;
        end
      end

`ifdef GAPR_GAP_EN
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = SEND;
          gap_d   = '0;
          x_d     = sr_q[PAT_W-1];
          valid_d = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
`endif

      FIN: begin
        // The done pulse is on the bus now. A start seen in this cycle is
        // dropped because this state does not look at it.
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register. Reset abandons any partial transfer without a done pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef GAPR_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef GAPR_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign bus.x_out = x_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_gerador_de_padrao.sv
// -----------------------------------------------------------------------------
// tb_gerador_de_padrao
//   Self-checking bench for gerador_de_padrao.
//
//   For each transaction, the expected per-cycle output stream
//   {x_out, valid, busy, done} is built from the transmitter's rules:
//     - count copies of the pattern, MSB first
//     - optional idle gaps between copies
//     - one done cycle
//     - one idle cycle
//   Each cycle of that stream is then compared with the DUT outputs.
//   While the DUT is busy, start and count are randomized to show that they
//   have no effect.
// -----------------------------------------------------------------------------
module tb_gerador_de_padrao;

  localparam int               PAT_W   = 4;
  localparam int               CNT_W   = 4;
  localparam int               GAP_LEN = 2;
  localparam logic [PAT_W-1:0] PAT     = 4'b1101;
`ifdef GAPR_GAP_EN
  localparam int GAPS = GAP_LEN;
`else
  localparam int GAPS = 0;
`endif

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  gerador_de_padrao_if #(.CNT_W(CNT_W)) bus ();

  gerador_de_padrao #(
    .PAT_W   (PAT_W),
    .PATTERN (PAT),
    .CNT_W   (CNT_W),
    .GAP_LEN (GAP_LEN)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;

  function automatic logic [3:0] outs();
    return {bus.x_out, bus.valid, bus.busy, bus.done};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got x/valid/busy/done=%b want %b", tag, obs, exp);
    end
  endtask

  // Call at a negedge with the DUT idle. On return the bench is at a negedge
  // again and the DUT is idle.
  task automatic run(input int cnt, input bit noise, input string name);
    logic [3:0]       q[$];
    logic [PAT_W-1:0] pat;

    pat = PAT;

    for (int r = 0; r < cnt; r++) begin
      for (int b = PAT_W - 1; b >= 0; b--) begin
        q.push_back({pat[b], 1'b1, 1'b1, 1'b0});
      end
      if (r < cnt - 1) begin
        for (int g = 0; g < GAPS; g++) begin
          q.push_back(4'b0010);
        end
      end
    end
    q.push_back(4'b0011);   // done cycle
    q.push_back(4'b0000);   // back to idle

    bus.start = 1'b1;
    bus.count = CNT_W'(cnt);

    foreach (q[i]) begin
      @(negedge clock);
      check($sformatf("%s[%0d]", name, i), outs(), q[i]);
      bus.count = CNT_W'($urandom);
      bus.start = (noise && (i < q.size() - 1)) ? 1'($urandom) : 1'b0;
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.count = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_state", outs(), 4'b0000);
    reset = 1'b0;

    // Directed cases.
    run(1,  0, "cnt1");
    run(3,  0, "cnt3");
    run(2,  0, "cnt2");
    run(0,  0, "cnt0");
    run(15, 1, "cntmax");
    run(1,  1, "cnt1_noise");

    // Reset in the middle of the first repetition.
    bus.start = 1'b1;
    bus.count = CNT_W'(2);
    @(negedge clock);
    check("rst_bit0", outs(), {PAT[3], 3'b110});
    bus.start = 1'b0;
    @(negedge clock);
    check("rst_bit1", outs(), {PAT[2], 3'b110});
    reset = 1'b1;
    @(negedge clock);
    check("rst_applied", outs(), 4'b0000);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("rst_quiet[%0d]", k), outs(), 4'b0000);
    end
    run(1, 0, "post_rst");

    // Randomized transactions.
    for (int t = 0; t < 10; t++) begin
      run($urandom_range(0, 15), 1'($urandom), $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
